deletezero: RTL and testbench
=============================

Name: deletezero

Overview:
- Zero-bit deletion (HDLC-style bit de-stuffing) for the RS-485 receive path.
- Takes a 48-bit stuffed word, scans it MSB-first, and removes each 0 that directly follows five consecutive 1s.
- Registers the first 40 surviving bits as the de-stuffed payload.
- Sits between the serial-to-parallel receiver and the frame/payload decoder.

Parameters:
- None. Widths are fixed: 48-bit input, 40-bit output.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-low reset (0 = reset asserted)
- data_in  input  48  stuffed word; bit 47 is the first bit on the wire
- out_data  output  40  de-stuffed word; bit 39 is the first surviving bit

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low: rst=0 forces out_data to 40'h0 immediately, regardless of clk.
- While rst=0, out_data holds 40'h0. After rst returns to 1, the first rising clk edge loads a computed value.
- No handshake and no valid signal. data_in is sampled on every rising clk edge when rst=1.
- Latency is 1 clock: out_data at edge N reflects data_in sampled at edge N.
- The de-stuffing function is purely combinational and is followed by a 40-bit output register.
- Scan order is bit 47 down to bit 0. A ones-counter starts at 0 for every word; no state is carried between words.
  - Input bit 1: keep the bit; counter = counter+1, saturating at 5.
  - Input bit 0 with counter = 5: delete the bit (stuffed zero); counter = 0.
  - Input bit 0 with counter < 5: keep the bit; counter = 0.
  - Six or more consecutive 1s (flag/abort pattern): all 1s are kept and nothing is deleted. The counter stays saturated at 5, so the next 0 after the run is deleted.
- Output packing:
  - Kept bits are packed MSB-first: the first kept bit goes to out_data[39], the next to [38], and so on.
  - At most 8 deletions are possible in 48 bits, so at least 40 bits always survive.
  - If more than 40 bits survive, only the first 40 are output; the surplus trailing kept bits are discarded.
- A stuffed zero at bit 0 (the word's last bit) is deleted like any other.
- A run of 1s ending at bit 0 has no effect on the next word.
- Changing data_in between edges has no effect until the next edge.
- Asserting reset mid-stream clears out_data at once. The first edge after release outputs the function of the data_in present at that edge.

Test Plan:
- Reset: rst=0 with data_in=48'hfbefbefbefbe, toggle clk → out_data stays 40'h0. Then set rst=1 → after the next rising edge out_data = 40'hffffffffff.
- Maximal stuffing: data_in=48'hfbefbefbefbe (eight groups of 111110) → 8 deletions, out_data = 40'hffffffffff one edge later.
- Two deletions with truncation: data_in=48'h03e494a54a7d → bits 36 and 1 deleted, 46 bits survive, out_data = 40'h03e9294a94.
- No stuffing: data_in=48'h0 → 40'h0. data_in=48'h123456789abc (no run of five 1s) → out_data = 40'h123456789a.
- Six-ones run: data_in=48'hfc0000000000 → bits 47..42 kept; bit 41 (the 0 after the saturated run) deleted; out_data = 40'hfc00000000.
- Async reset mid-operation: with out_data=40'hffffffffff, drive rst=0 between clk edges → out_data = 40'h0 immediately, before the next edge.

Source files
------------

// File: rtl/deletezero.sv
// ---------------------------------------------------------------------------
// deletezero
//    Zero-bit deletion (HDLC-style bit de-stuffing) for the RS-485 receive
//    path. A 48-bit stuffed word is scanned MSB-first. Every 0 that directly
//    follows five consecutive 1s is removed. The first 40 surviving bits are
//    registered as the de-stuffed payload.
//
//    Each word is de-stuffed on its own: the ones counter restarts at zero
//    for every word, so a run of 1s at the end of one word does not affect
//    the next word.
//
// Ports
//    clk       in   1   system clock, rising-edge active
//    rst       in   1   asynchronous active-low reset (0 clears out_data)
//    data_in   in  48   stuffed word, bit 47 is the first bit on the wire
//    out_data  out 40   de-stuffed word, bit 39 is the first surviving bit
// ---------------------------------------------------------------------------
module deletezero (
   input  logic        clk,
   input  logic        rst,
   input  logic [47:0] data_in,
   output logic [39:0] out_data
);

   // One bit per input position: 1 = the bit survives, 0 = stuffed zero.
   logic [47:0] keep_mask_s;
   // First 40 surviving bits, packed MSB-first.
   logic [39:0] packed_s;

   // Mark the surviving bits. The counter saturates at 5, so a run of six or
   // more 1s (flag/abort) keeps every 1, and the next 0 is still deleted.
   always_comb begin
      logic [2:0] ones_v;
      keep_mask_s = 48'h0;
      ones_v      = 3'd0;
      for (int i = 47; i >= 0; i--) begin
         if (data_in[i]) begin
            keep_mask_s[i] = 1'b1;
            if (ones_v != 3'd5) begin
               ones_v = ones_v + 3'd1;
            end else begin
               ones_v = ones_v;
            end
         end else if (ones_v == 3'd5) begin
            keep_mask_s[i] = 1'b0;
            ones_v         = 3'd0;
         end else begin
            keep_mask_s[i] = 1'b1;
            ones_v         = 3'd0;
         end
      end
   end

   // Pack the surviving bits MSB-first by shifting them in from the right.
   // At most 8 bits can be deleted, so at least 40 bits always survive. After
   // 40 shifts the first surviving bit sits in bit 39. Surplus bits at the
   // end of the word are dropped.
   always_comb begin
      logic [5:0] taken_v;
      packed_s = 40'h0;
      taken_v  = 6'd0;
      for (int i = 47; i >= 0; i--) begin
         if (keep_mask_s[i] && (taken_v < 6'd40)) begin
            packed_s = {packed_s[38:0], data_in[i]};
            taken_v  = taken_v + 6'd1;
         end else begin
            packed_s = packed_s;
            taken_v  = taken_v;
         end
      end
   end

   // Output register. The asynchronous reset clears the payload at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_data <= 40'h0;
      end else begin
         out_data <= packed_s;
      end
   end

endmodule

// File: tb/tb_deletezero.sv
// ---------------------------------------------------------------------------
// tb_deletezero
//    Self-checking bench for deletezero. It runs the directed cases first,
//    then random words. Random words are compared against a queue-based
//    reference model of the de-stuffing rule.
// ---------------------------------------------------------------------------
module tb_deletezero;

   logic        clk;
   logic        rst;
   logic [47:0] data_in;
   logic [39:0] out_data;

   int passes;
   int checks;

   deletezero dut (
      .clk      (clk),
      .rst      (rst),
      .data_in  (data_in),
      .out_data (out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: walk the wire bits, count consecutive 1s and drop a 0
   // after five or more of them. The survivors go into a queue, and the
   // result is the first 40 entries of that queue.
   function automatic logic [39:0] ref_destuff(input logic [47:0] w);
      bit          q[$];
      int          ones;
      logic [39:0] r;
      ones = 0;
      for (int i = 47; i >= 0; i--) begin
         if (w[i]) begin
            q.push_back(1'b1);
            ones++;
         end else if (ones >= 5) begin
            ones = 0;
         end else begin
            q.push_back(1'b0);
            ones = 0;
         end
      end
      r = 40'h0;
      for (int k = 0; k < 40; k++) r[39-k] = q[k];
      return r;
   endfunction

   task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
      checks++;
      assert (got === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, got, exp);
   endtask

   // Drive a word at the falling edge. Sample 1 time unit after the next
   // rising edge.
   task automatic apply(input logic [47:0] w);
      @(negedge clk);
      data_in = w;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [47:0] w;
      logic [39:0] held;
      passes  = 0;
      checks  = 0;
      rst     = 1'b0;
      data_in = 48'hfbefbefbefbe;

      // Reset held low while the clock runs.
      #1;
      check("reset_immediate", out_data, 40'h0);
      repeat (3) @(posedge clk);
      #1;
      check("reset_hold", out_data, 40'h0);

      // Release reset. The first edge loads the computed value.
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("reset_release", out_data, 40'hffffffffff);

      apply(48'h0);
      check("all_zero", out_data, 40'h0);
      apply(48'hfbefbefbefbe);
      check("max_stuffing", out_data, 40'hffffffffff);
      apply(48'h03e494a54a7d);
      check("two_del_trunc", out_data, 40'h03e9294a94);
      apply(48'h123456789abc);
      check("no_stuffing", out_data, 40'h123456789a);
      apply(48'hfc0000000000);
      check("six_ones", out_data, 40'hfc00000000);
      apply(48'hffffffffffff);
      check("all_ones", out_data, 40'hffffffffff);
      // Stuffed zero at bit 0, then a word that starts with a 0.
      apply(48'h00000000003e);
      check("stuff_at_bit0", out_data, 40'h0000000000);
      apply(48'h00000000001f);
      check("run_at_end", out_data, 40'h0000000000);
      apply(48'h7fffffffffff);
      check("no_carry", out_data, 40'h7fffffffff);

      // A change in data_in between edges has no effect until the next edge.
      apply(48'h123456789abc);
      data_in = 48'h0;
      #2;
      check("hold_between_edges", out_data, 40'h123456789a);
      @(posedge clk);
      #1;
      check("next_edge_update", out_data, 40'h0);

      // Asynchronous reset in the middle of a cycle.
      apply(48'hfbefbefbefbe);
      check("pre_async", out_data, 40'hffffffffff);
      #2;
      rst = 1'b0;
      #1;
      check("async_clear", out_data, 40'h0);
      @(negedge clk);
      data_in = 48'h123456789abc;
      rst     = 1'b1;
      @(posedge clk);
      #1;
      check("after_async", out_data, 40'h123456789a);

      // Random words, some plain and some built from stuffing-heavy chunks.
      for (int n = 0; n < 300; n++) begin
         if (n % 2 == 0) begin
            w = {16'($urandom), 32'($urandom)};
         end else begin
            w = 48'h0;
            for (int c = 0; c < 8; c++) begin
               case ($urandom_range(0, 3))
                  0:       w = {w[41:0], 6'b111110};
                  1:       w = {w[41:0], 6'b111111};
                  2:       w = {w[41:0], 6'b011111};
                  default: w = {w[41:0], 6'($urandom)};
               endcase
            end
         end
         apply(w);
         check("random", out_data, ref_destuff(w));
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
